glb_bank_req_ctrl: RTL and testbench
====================================

# glb_bank_req_ctrl

Request front-end for one GLB bank, directly upstream of the bank memory. Accepts independent valid/ready write and read request streams, arbitrates them onto the single-port memory interface (one access per cycle), and expands byte strobes to the memory's bit-select. Tracks the memory's fixed read latency with a tag pipeline and returns registered read data with valid and tag.

## Interface
- `RD_LATENCY`, 3: cycles from `mem_ren` high to `mem_data_out` carrying that read's data.
- `TAG_WIDTH`, 8: read-request tag width.
- `BANK_ADDR_WIDTH`, `BANK_DATA_WIDTH`, `BANK_BYTE_OFFSET`: from `global_buffer_param`; `BANK_STRB_WIDTH = BANK_DATA_WIDTH/8`.
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1, `wr_ready` out 1: write handshake.
- `wr_addr` in BANK_ADDR_WIDTH: byte address.
- `wr_data` in BANK_DATA_WIDTH: write data.
- `wr_strb` in BANK_STRB_WIDTH: byte enables.
- `rd_valid` in 1, `rd_ready` out 1: read handshake.
- `rd_addr` in BANK_ADDR_WIDTH: byte address.
- `rd_tag` in TAG_WIDTH: returned with data.
- `mem_wen`, `mem_ren` out 1: to bank memory.
- `mem_addr` out BANK_ADDR_WIDTH: to bank memory.
- `mem_data_in`, `mem_bit_sel` out BANK_DATA_WIDTH: to bank memory.
- `mem_data_out` in BANK_DATA_WIDTH: from bank memory.
- `rsp_valid` out 1, `rsp_data` out BANK_DATA_WIDTH, `rsp_tag` out TAG_WIDTH: read response; no backpressure.

## Operation
- Handshake: transfer when `valid && ready`. Each cycle, at most one of `wr_ready`/`rd_ready` is high.
- Arbitration: the `prio` register holds WR or RD and resets to WR.
  - Only one stream valid: that stream is granted.
  - Both valid: the `prio` side is granted and `prio` flips to the other side.
  - Neither valid: no grant; `prio` holds.
  - `ready` may depend combinationally on both `valid`s. `ready` is high for the granted side only; with no valid request, `wr_ready=1` and `rd_ready=0`.
- Memory drive is combinational from the granted request, with no added latency:
  - `mem_wen = wr_valid && wr_ready`.
  - `mem_ren = rd_valid && rd_ready`.
  - `mem_addr` comes from the granted request's address.
  - `mem_data_in = wr_data`.
  - `mem_bit_sel[8i+7:8i] = {8{wr_strb[i]}}`.
  - When idle, `mem_addr`, `mem_data_in` and `mem_bit_sel` are 0.
- Zero-strobe write: `wr_strb==0` is accepted (`wr_ready` high) but `mem_wen` stays 0. It still consumes the arbitration slot and flips `prio` if contended.
- Tag pipeline: a RD_LATENCY-deep shift register of {valid, tag} is loaded from `mem_ren`/`rd_tag` and advances every cycle.
- Response: at the pipeline tail, `rsp_valid`, `rsp_tag` and `rsp_data <= mem_data_out` are registered.
  - `rsp_data` holds its value when `rsp_valid` is 0.
  - Back-to-back reads yield back-to-back responses, in order.
- Ordering: a read accepted after a write to the same address returns the new data, because the memory is single-port and in order. No hazard logic is needed.

## Timing
- Read accepted at cycle T: `mem_ren=1` at T; `rsp_valid=1` at T+RD_LATENCY+1 (default T+4) with that tag.
- Write accepted at T: `mem_wen=1` at T.
- Throughput is one access per cycle. Contended streams alternate, so each gets 50%.
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_tag=0`.
  - All tag-pipeline valids 0; `prio=WR`.
  - `wr_ready` and `rd_ready` follow the combinational rules (`wr_ready=1` when idle).
- Reset mid-operation: in-flight reads are discarded and no response is produced for them. After deassertion, the first grant uses `prio=WR`.
- `reset_n` assertion is asynchronous; deassertion is synchronized externally.

## Structure
- Add `BANK_STRB_WIDTH` to `global_buffer_param`.
- Add to `global_buffer_pkg`:
  - `typedef enum logic {PRIO_WR, PRIO_RD} glb_bank_prio_e`.
  - A packed struct `{valid, tag}` for pipeline entries.
- One sub-module, `glb_shift_pipe`, parameterized by DEPTH and WIDTH with async active-low reset. It carries the tag/valid delay line.

## Test plan
- Single write then read: write addr 0x10, data 0xDEADBEEF_CAFEF00D, strb all ones; read addr 0x10, tag 0x5A → `rsp_valid` 4 cycles after the read handshake, data 0xDEADBEEF_CAFEF00D, tag 0x5A.
- Partial strobe: `wr_strb=0x0F` → `mem_bit_sel=0x00000000_FFFFFFFF` in the same cycle. `wr_strb=0` → `wr_ready=1` and `mem_wen=0`.
- Contention: both streams held valid for 6 cycles → grants W,R,W,R,W,R; never both `ready`; 3 responses with tags in issue order.
- Streaming reads: 8 consecutive reads, tags 0..7 → 8 consecutive `rsp_valid` cycles, tags 0..7 in order.
- Read-after-write: write 0xAA to addr 0x20, then read 0x20 on the next cycle → response 0xAA.
- Reset mid-flight: 2 reads issued, then `reset_n` low 1 cycle → no `rsp_valid` for them, `prio=WR`, all outputs at reset values.

Source files
------------

// File: rtl/global_buffer_param.sv
// Global buffer geometry shared by all GLB banks.
// Strobe width is one enable per data byte.
package global_buffer_param;
  localparam int BANK_ADDR_WIDTH  = 17;
  localparam int BANK_DATA_WIDTH  = 64;
  localparam int BANK_STRB_WIDTH  = BANK_DATA_WIDTH / 8;
  localparam int BANK_BYTE_OFFSET = $clog2(BANK_STRB_WIDTH);
endpackage

// File: rtl/global_buffer_pkg.sv
// Shared types for the GLB bank request path.
// Arbitration priority and read-tag pipeline entry.
package global_buffer_pkg;
  localparam int GLB_TAG_WIDTH = 8;

  typedef enum logic {
    PRIO_WR,
    PRIO_RD
  } glb_bank_prio_e;

  typedef struct packed {
    logic                     valid;
    logic [GLB_TAG_WIDTH-1:0] tag;
  } glb_tag_ent_t;
endpackage

// File: rtl/glb_shift_pipe.sv
// Fixed-depth delay line with async active-low clear.
// Every stage advances each cycle.
module glb_shift_pipe #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/glb_bank_req_ctrl.sv
// GLB bank front-end: write/read arbitration onto a single-port
// memory, strobe expansion, and tagged fixed-latency read return.
module glb_bank_req_ctrl
  import global_buffer_param::*;
  import global_buffer_pkg::*;
#(
  parameter int RD_LATENCY = 3,
  parameter int TAG_WIDTH  = GLB_TAG_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,

  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [BANK_ADDR_WIDTH-1:0] wr_addr,
  input  logic [BANK_DATA_WIDTH-1:0] wr_data,
  input  logic [BANK_STRB_WIDTH-1:0] wr_strb,

  input  logic                       rd_valid,
  output logic                       rd_ready,
  input  logic [BANK_ADDR_WIDTH-1:0] rd_addr,
  input  logic [TAG_WIDTH-1:0]       rd_tag,

  output logic                       mem_wen,
  output logic                       mem_ren,
  output logic [BANK_ADDR_WIDTH-1:0] mem_addr,
  output logic [BANK_DATA_WIDTH-1:0] mem_data_in,
  output logic [BANK_DATA_WIDTH-1:0] mem_bit_sel,
  input  logic [BANK_DATA_WIDTH-1:0] mem_data_out,

  output logic                       rsp_valid,
  output logic [BANK_DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]       rsp_tag
);

  glb_bank_prio_e r_prio;
  glb_bank_prio_e w_prio_nxt;

  logic w_grant_wr;
  logic w_grant_rd;

  logic [BANK_DATA_WIDTH-1:0] w_bit_sel;

  glb_tag_ent_t w_ent_in;
  glb_tag_ent_t w_ent_tail;

  logic                       r_rsp_valid;
  logic [BANK_DATA_WIDTH-1:0] r_rsp_data;
  logic [TAG_WIDTH-1:0]       r_rsp_tag;

  always_comb begin
    w_grant_wr = wr_valid && (!rd_valid || r_prio == PRIO_WR);
    w_grant_rd = rd_valid && (!wr_valid || r_prio == PRIO_RD);
    w_prio_nxt = r_prio;
    if (wr_valid && rd_valid) begin
      w_prio_nxt = (r_prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_prio <= PRIO_WR;
    else          r_prio <= w_prio_nxt;
  end

  // Idle cycles park wr_ready high so a lone write needs no extra cycle.
  assign wr_ready = !rd_valid || w_grant_wr;
  assign rd_ready = w_grant_rd;

  always_comb begin
    w_bit_sel = '0;
    for (int i = 0; i < BANK_STRB_WIDTH; i++) begin
      w_bit_sel[8*i +: 8] = {8{wr_strb[i]}};
    end
  end

  always_comb begin
    mem_wen     = 1'b0;
    mem_ren     = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_bit_sel = '0;
    unique case (1'b1)
      w_grant_wr: begin
        mem_wen     = |wr_strb;
        mem_addr    = wr_addr;
        mem_data_in = wr_data;
        mem_bit_sel = w_bit_sel;
      end
      w_grant_rd: begin
        mem_ren  = 1'b1;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_ent_in       = '0;
    w_ent_in.valid = mem_ren;
    w_ent_in.tag   = rd_tag;
  end

  glb_shift_pipe #(
    .DEPTH (RD_LATENCY),
    .WIDTH ($bits(glb_tag_ent_t))
  ) u_tag_pipe (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (w_ent_in),
    .o_q     (w_ent_tail)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
    end else begin
      r_rsp_valid <= w_ent_tail.valid;
      if (w_ent_tail.valid) begin
        r_rsp_data <= mem_data_out;
        r_rsp_tag  <= w_ent_tail.tag;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;

endmodule

// File: tb/tb_glb_bank_req_ctrl.sv
// Directed bench for glb_bank_req_ctrl with a 3-cycle
// behavioural bank memory and a response recorder.
module tb_glb_bank_req_ctrl;

  logic        clk;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [16:0] wr_addr;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        rd_valid;
  logic        rd_ready;
  logic [16:0] rd_addr;
  logic [7:0]  rd_tag;
  logic        mem_wen;
  logic        mem_ren;
  logic [16:0] mem_addr;
  logic [63:0] mem_data_in;
  logic [63:0] mem_bit_sel;
  logic [63:0] mem_data_out;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic [7:0]  rsp_tag;

  glb_bank_req_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_strb      (wr_strb),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_addr      (rd_addr),
    .rd_tag       (rd_tag),
    .mem_wen      (mem_wen),
    .mem_ren      (mem_ren),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_bit_sel  (mem_bit_sel),
    .mem_data_out (mem_data_out),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_tag      (rsp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank memory: 256 x 64b, write visible next cycle, 3-cycle read.
  logic [63:0] mem [256];
  logic [63:0] p0, p1, p2;
  logic [7:0]  idx;
  assign idx = mem_addr[10:3];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    p0 = '0;
    p1 = '0;
    p2 = '0;
  end

  always @(posedge clk) begin
    p0 <= mem[idx];
    p1 <= p0;
    p2 <= p1;
    if (mem_wen)
      mem[idx] <= (mem[idx] & ~mem_bit_sel) | (mem_data_in & mem_bit_sel);
  end

  assign mem_data_out = p2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  q_tag [$];
  logic [63:0] q_data [$];
  int          q_cyc [$];

  always @(negedge clk) begin
    if (rsp_valid) begin
      q_tag.push_back(rsp_tag);
      q_data.push_back(rsp_data);
      q_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_q;
    q_tag.delete();
    q_data.delete();
    q_cyc.delete();
  endtask

  function automatic logic [7:0] qt(input int k);
    return (q_tag.size() > k) ? q_tag[k] : 8'hxx;
  endfunction

  function automatic logic [63:0] qd(input int k);
    return (q_data.size() > k) ? q_data[k] : 64'hx;
  endfunction

  function automatic int qc(input int k);
    return (q_cyc.size() > k) ? q_cyc[k] : -1;
  endfunction

  int t0;

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    rd_tag   = '0;
    repeat (2) tick;

    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_rd_ready", rd_ready, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_mem_ren", mem_ren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_bit_sel", mem_bit_sel, 0);
    chk("rst_data_in", mem_data_in, 0);
    reset_n = 1'b1;
    tick;

    // single write then read
    wr_valid = 1'b1;
    wr_addr  = 17'h10;
    wr_data  = 64'hDEADBEEF_CAFEF00D;
    wr_strb  = 8'hFF;
    #1;
    chk("w1_wr_ready", wr_ready, 1);
    chk("w1_mem_wen", mem_wen, 1);
    chk("w1_mem_addr", mem_addr, 64'h10);
    chk("w1_data_in", mem_data_in, 64'hDEADBEEF_CAFEF00D);
    chk("w1_bit_sel", mem_bit_sel, 64'hFFFFFFFF_FFFFFFFF);
    tick;
    wr_valid = 1'b0;
    clr_q();
    rd_valid = 1'b1;
    rd_addr  = 17'h10;
    rd_tag   = 8'h5A;
    #1;
    chk("r1_rd_ready", rd_ready, 1);
    chk("r1_mem_ren", mem_ren, 1);
    chk("r1_mem_wen", mem_wen, 0);
    chk("r1_mem_addr", mem_addr, 64'h10);
    t0 = cyc;
    tick;
    rd_valid = 1'b0;
    repeat (6) tick;
    chk("r1_count", q_tag.size(), 1);
    chk("r1_tag", qt(0), 8'h5A);
    chk("r1_data", qd(0), 64'hDEADBEEF_CAFEF00D);
    chk("r1_latency", qc(0) - t0, 4);

    // partial and zero strobe
    wr_valid = 1'b1;
    wr_addr  = 17'h30;
    wr_data  = 64'h11223344_55667788;
    wr_strb  = 8'h0F;
    #1;
    chk("ps_bit_sel", mem_bit_sel, 64'h00000000_FFFFFFFF);
    chk("ps_mem_wen", mem_wen, 1);
    tick;
    wr_data = 64'hFFFFFFFF_FFFFFFFF;
    wr_strb = 8'h00;
    #1;
    chk("zs_wr_ready", wr_ready, 1);
    chk("zs_mem_wen", mem_wen, 0);
    chk("zs_bit_sel", mem_bit_sel, 0);
    tick;
    wr_valid = 1'b0;
    clr_q();
    rd_valid = 1'b1;
    rd_addr  = 17'h30;
    rd_tag   = 8'h33;
    tick;
    rd_valid = 1'b0;
    repeat (6) tick;
    chk("ps_count", q_tag.size(), 1);
    chk("ps_data", qd(0), 64'h00000000_55667788);

    // contention: W,R,W,R,W,R
    clr_q();
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 17'h100;
      wr_data  = 64'(i);
      wr_strb  = 8'hFF;
      rd_valid = 1'b1;
      rd_addr  = 17'h10;
      rd_tag   = 8'h10 + 8'(i);
      #1;
      chk($sformatf("ct%0d_wr_ready", i), wr_ready, ((i % 2) == 0) ? 1 : 0);
      chk($sformatf("ct%0d_rd_ready", i), rd_ready, ((i % 2) == 1) ? 1 : 0);
      chk($sformatf("ct%0d_both", i), wr_ready && rd_ready, 0);
      tick;
    end
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    repeat (8) tick;
    chk("ct_count", q_tag.size(), 3);
    chk("ct_tag0", qt(0), 8'h11);
    chk("ct_tag1", qt(1), 8'h13);
    chk("ct_tag2", qt(2), 8'h15);

    // streaming reads
    clr_q();
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      rd_valid = 1'b1;
      rd_addr  = 17'h10;
      rd_tag   = 8'(i);
      tick;
    end
    rd_valid = 1'b0;
    repeat (8) tick;
    chk("st_count", q_tag.size(), 8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("st%0d_tag", k), qt(k), 8'(k));
      chk($sformatf("st%0d_cyc", k), qc(k) - t0, 4 + k);
    end

    // read after write
    clr_q();
    wr_valid = 1'b1;
    wr_addr  = 17'h20;
    wr_data  = 64'hAA;
    wr_strb  = 8'hFF;
    tick;
    wr_valid = 1'b0;
    rd_valid = 1'b1;
    rd_addr  = 17'h20;
    rd_tag   = 8'h77;
    tick;
    rd_valid = 1'b0;
    repeat (6) tick;
    chk("raw_count", q_tag.size(), 1);
    chk("raw_data", qd(0), 64'hAA);
    chk("raw_tag", qt(0), 8'h77);

    // reset mid-flight with prio left at RD
    clr_q();
    wr_valid = 1'b1;
    wr_addr  = 17'h40;
    wr_data  = 64'h1;
    rd_valid = 1'b1;
    rd_addr  = 17'h10;
    rd_tag   = 8'hEE;
    #1;
    chk("rm_pre_wr_ready", wr_ready, 1);
    tick;
    wr_valid = 1'b0;
    rd_tag   = 8'hE1;
    tick;
    rd_tag   = 8'hE2;
    tick;
    rd_valid = 1'b0;
    reset_n  = 1'b0;
    #1;
    chk("rm_rsp_valid", rsp_valid, 0);
    chk("rm_rsp_data", rsp_data, 0);
    chk("rm_rsp_tag", rsp_tag, 0);
    chk("rm_wr_ready", wr_ready, 1);
    chk("rm_rd_ready", rd_ready, 0);
    tick;
    reset_n  = 1'b1;
    wr_valid = 1'b1;
    rd_valid = 1'b1;
    rd_tag   = 8'hE3;
    #1;
    chk("rm_prio_wr_ready", wr_ready, 1);
    chk("rm_prio_rd_ready", rd_ready, 0);
    tick;
    wr_valid = 1'b0;
    rd_valid = 1'b0;
    repeat (8) tick;
    chk("rm_no_rsp", q_tag.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
